// File: rtl/laser_pkg.sv
// laser_pkg: shared types and default byte patterns for the laser link (rev 1.0).
// Shared by the transmit scheduler and the receiver-side deframer.
`default_nettype none

package laser_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    CHECKSUM = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SYNC_BYTE     = 8'hD5;
  localparam logic [7:0] PAD_BYTE      = 8'h00;

endpackage

`default_nettype wire

// File: rtl/laser_pair_stager.sv
// laser_pair_stager: two-byte payload staging with lane steering and underflow padding (rev 1.0).
`default_nettype none

module laser_pair_stager #(
  parameter logic [7:0] PAD_BYTE    = laser_pkg::PAD_BYTE,
  parameter int         STALL_LIMIT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       active,
  input  logic       hold,
  input  logic       take,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] lane1,
  output logic [7:0] lane2,
  output logic       full,
  output logic       underflow
);

  localparam int                   STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT);

  logic [1:0]         r_count;
  logic [STALL_W-1:0] r_stall;
  logic               r_pad;
  logic               w_accept;
  logic               w_starve;
  logic               w_fill;

  assign full     = (r_count == 2'd2);
  assign in_ready = active && !r_pad && !hold && !full;
  assign w_accept = in_valid && in_ready;
  assign w_starve = active && !r_pad && !full && !in_valid;
  // Once padding starts it persists: every later slot is filled immediately.
  assign w_fill   = (r_pad && !full) || (w_starve && (r_stall == STALL_MAX));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count   <= 2'd0;
      r_stall   <= '0;
      r_pad     <= 1'b0;
      lane1     <= 8'h00;
      lane2     <= 8'h00;
      underflow <= 1'b0;
    end else if (!active) begin
      r_count   <= 2'd0;
      r_stall   <= '0;
      r_pad     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (take) begin
        r_count <= 2'd0;
      end else if (w_accept) begin
        if (r_count == 2'd0) lane1 <= in_data;
        else                 lane2 <= in_data;
        r_count <= r_count + 2'd1;
        r_stall <= '0;
      end else if (w_fill) begin
        if (r_count == 2'd0) lane1 <= PAD_BYTE;
        lane2   <= PAD_BYTE;
        r_count <= 2'd2;
        r_stall <= '0;
        if (!r_pad) begin
          r_pad     <= 1'b1;
          underflow <= 1'b1;
        end
      end else if (w_starve) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/laser_tx_scheduler.sv
// laser_tx_scheduler: frames an upstream byte stream into fixed-length packets and
// hands them to the dual-lane transmitter as byte pairs (rev 1.0).
`default_nettype none

module laser_tx_scheduler #(
  parameter int         PAYLOAD_PAIRS  = 16,
  parameter int         PREAMBLE_PAIRS = 2,
  parameter logic [7:0] PREAMBLE_BYTE  = laser_pkg::PREAMBLE_BYTE,
  parameter logic [7:0] SYNC_BYTE      = laser_pkg::SYNC_BYTE,
  parameter logic [7:0] PAD_BYTE       = laser_pkg::PAD_BYTE,
  parameter int         STALL_LIMIT    = 255,
  parameter int         GAP_CYCLES     = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] tx_data1,
  output logic [7:0] tx_data2,
  output logic       tx_valid,
  input  logic       tx_done,
  output logic [7:0] seq_num,
  output logic       busy,
  output logic       pkt_done,
  output logic       underflow
);

  import laser_pkg::*;

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_PAIRS - 1);
  localparam logic [7:0]       PAY_LAST = 8'(PAYLOAD_PAIRS - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_pair, w_pair_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [7:0]       r_xor1, r_xor2, w_xor1_nxt, w_xor2_nxt;
  logic [7:0]       w_d1_nxt, w_d2_nxt, w_seq_nxt;
  logic             w_valid_nxt, w_pkt_done_nxt;
  logic             w_done, w_take;
  logic [7:0]       w_lane1, w_lane2;
  logic             w_full;

  assign w_done = tx_valid && tx_done;
  assign busy   = (r_state != IDLE);

  laser_pair_stager #(
    .PAD_BYTE    (PAD_BYTE),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stager (
    .clock     (clock),
    .reset     (reset),
    .active    (r_state == PAYLOAD),
    .hold      (tx_valid),
    .take      (w_take),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lane1     (w_lane1),
    .lane2     (w_lane2),
    .full      (w_full),
    .underflow (underflow)
  );

  // A pair is only presented while tx_valid is low, so the cycle after a
  // consumption is always idle on the handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_pair_nxt     = r_pair;
    w_gap_nxt      = r_gap;
    w_xor1_nxt     = r_xor1;
    w_xor2_nxt     = r_xor2;
    w_seq_nxt      = seq_num;
    w_valid_nxt    = tx_valid && !w_done;
    w_d1_nxt       = tx_data1;
    w_d2_nxt       = tx_data2;
    w_pkt_done_nxt = 1'b0;
    w_take         = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && in_valid) begin
          w_state_nxt = PREAMBLE;
          w_pair_nxt  = 8'd0;
          w_xor1_nxt  = 8'h00;
          w_xor2_nxt  = 8'h00;
        end
      end
      PREAMBLE: begin
        if (!tx_valid) begin
          w_valid_nxt = 1'b1;
          w_d1_nxt    = PREAMBLE_BYTE;
          w_d2_nxt    = PREAMBLE_BYTE;
        end
        if (w_done) begin
          if (r_pair == PRE_LAST) begin
            w_state_nxt = HEADER;
            w_pair_nxt  = 8'd0;
          end else begin
            w_pair_nxt = r_pair + 8'd1;
          end
        end
      end
      HEADER: begin
        if (!tx_valid) begin
          w_valid_nxt = 1'b1;
          w_d1_nxt    = SYNC_BYTE;
          w_d2_nxt    = seq_num;
        end
        if (w_done) w_state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (!tx_valid && w_full) begin
          w_valid_nxt = 1'b1;
          w_d1_nxt    = w_lane1;
          w_d2_nxt    = w_lane2;
          w_take      = 1'b1;
          w_xor1_nxt  = r_xor1 ^ w_lane1;
          w_xor2_nxt  = r_xor2 ^ w_lane2;
        end
        if (w_done) begin
          if (r_pair == PAY_LAST) begin
            w_state_nxt = CHECKSUM;
            w_pair_nxt  = 8'd0;
          end else begin
            w_pair_nxt = r_pair + 8'd1;
          end
        end
      end
      CHECKSUM: begin
        if (!tx_valid) begin
          w_valid_nxt = 1'b1;
          w_d1_nxt    = r_xor1;
          w_d2_nxt    = r_xor2;
        end
        if (w_done) begin
          w_pkt_done_nxt = 1'b1;
          w_seq_nxt      = seq_num + 8'd1;
          w_state_nxt    = GAP;
          w_gap_nxt      = '0;
        end
      end
      GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = IDLE;
        else                   w_gap_nxt   = r_gap + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pair   <= 8'd0;
      r_gap    <= '0;
      r_xor1   <= 8'h00;
      r_xor2   <= 8'h00;
      seq_num  <= 8'd0;
      tx_valid <= 1'b0;
      tx_data1 <= 8'h00;
      tx_data2 <= 8'h00;
      pkt_done <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pair   <= w_pair_nxt;
      r_gap    <= w_gap_nxt;
      r_xor1   <= w_xor1_nxt;
      r_xor2   <= w_xor2_nxt;
      seq_num  <= w_seq_nxt;
      tx_valid <= w_valid_nxt;
      tx_data1 <= w_d1_nxt;
      tx_data2 <= w_d2_nxt;
      pkt_done <= w_pkt_done_nxt;
    end
  end

endmodule

`default_nettype wire
